// File: rtl/boat_queue.sv
// boat_queue: edge-detected boat arrivals queued by direction and granted one lockage at a time; optional head-wait timer under BOAT_QUEUE_WAIT_TIMER_EN
module boat_queue #(
  parameter int DEPTH = 4,
  parameter int MAX_WAIT = 300
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     sec_tick,
  input  logic                     arrive,
  input  logic                     arrive_dir,
  input  logic                     lock_ready,
  input  logic                     lock_done,
  output logic                     req_valid,
  output logic                     req_dir,
  output logic                     serving,
  output logic                     serving_dir,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [8:0]               head_wait,
  output logic                     wait_alarm
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, PRESENT, SERVING} state_t;
  state_t state, state_n;
  logic arrive_q, enq, enq_ok, grant;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_n;
  logic mem [DEPTH];
  assign enq = arrive & ~arrive_q;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign enq_ok = enq & ~full;
  assign req_valid = state == PRESENT;
  assign serving = state == SERVING;
  assign grant = req_valid & lock_ready;
  assign req_dir = req_valid & mem[rd_ptr];
  assign count_n = count + CW'(enq_ok) - CW'(grant);
  // next state: a lockage in progress blocks further grants until lock_done
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)    ? (empty ? IDLE : PRESENT) :
              (state == PRESENT) ? (lock_ready ? SERVING : PRESENT) :
              (lock_done ? (count_n != '0 ? PRESENT : IDLE) : SERVING);
  end
  // state, pointers, count, arrival edge detect and sticky overflow
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      arrive_q <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      serving_dir <= 1'b0;
    end else begin
      state <= state_n;
      arrive_q <= arrive;
      count <= count_n;
      if (enq_ok) wr_ptr <= wr_ptr + AW'(1);
      if (grant) rd_ptr <= rd_ptr + AW'(1);
      if (grant) serving_dir <= mem[rd_ptr];
      if (enq & full) overflow <= 1'b1;
    end
  end
  // direction storage; contents behind the pointers are don't-care after reset
  always_ff @(posedge CLOCK_50) begin
    if (enq_ok) mem[wr_ptr] <= arrive_dir;
  end
`ifdef BOAT_QUEUE_WAIT_TIMER_EN
  logic [8:0] head_wait_n;
  // head wait restarts on grant or an empty queue, otherwise counts seconds up to 511
  always_comb begin
    head_wait_n = head_wait;
    head_wait_n = (grant || empty) ? 9'd0 :
                  (sec_tick && head_wait != 9'd511) ? head_wait + 9'd1 : head_wait;
  end
  // alarm registered from the same next value so it tracks head_wait exactly
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      head_wait <= 9'd0;
      wait_alarm <= 1'b0;
    end else begin
      head_wait <= head_wait_n;
      wait_alarm <= head_wait_n >= 9'(MAX_WAIT);
    end
  end
`else
  logic unused_sec_tick;
  assign unused_sec_tick = sec_tick;
  assign head_wait = 9'd0;
  assign wait_alarm = 1'b0;
`endif
endmodule
